// File: rtl/decode_issue_if.sv
// Decode/issue stage bundle: IF/ID input, writeback and load-completion feeds, ID/EX output.
// master = the decode stage, slave = its surroundings.
interface decode_issue_if #(
  parameter int XLEN = 32,
  parameter int FLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic            flush_d;
  logic            RegWriteW;
  logic [4:0]      RD_W;
  logic [XLEN-1:0] ResultW;
  logic            FPRegWriteW;
  logic [4:0]      FP_RD_W;
  logic [FLEN-1:0] FP_ResultW;
  logic            ld_done_w;
  logic [4:0]      ld_rd_w;
  logic            ld_fp_w;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     InstrE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [FLEN-1:0] FPRD1E;
  logic [FLEN-1:0] FPRD2E;
  logic [XLEN-1:0] ImmE;
  logic [4:0]      RS1E;
  logic [4:0]      RS2E;
  logic [4:0]      RDE;
  logic            is_fpE;
  logic            is_loadE;
  logic            is_storeE;
  logic            is_branchE;

  modport master (
    input  in_valid, InstrD, PCD, flush_d, RegWriteW, RD_W, ResultW,
           FPRegWriteW, FP_RD_W, FP_ResultW, ld_done_w, ld_rd_w, ld_fp_w, out_ready,
    output in_ready, out_valid, InstrE, PCE, RD1E, RD2E, FPRD1E, FPRD2E, ImmE,
           RS1E, RS2E, RDE, is_fpE, is_loadE, is_storeE, is_branchE
  );

  modport slave (
    output in_valid, InstrD, PCD, flush_d, RegWriteW, RD_W, ResultW,
           FPRegWriteW, FP_RD_W, FP_ResultW, ld_done_w, ld_rd_w, ld_fp_w, out_ready,
    input  in_ready, out_valid, InstrE, PCE, RD1E, RD2E, FPRD1E, FPRD2E, ImmE,
           RS1E, RS2E, RDE, is_fpE, is_loadE, is_storeE, is_branchE
  );
endinterface

// File: rtl/decode_issue_stage.sv
// RV32IMFA decode/issue: int and FP register files with write-through bypass,
// load-use scoreboard stall, and a registered ID/EX slot with valid/ready and flush.
module decode_issue_stage #(
  parameter int XLEN      = 32,
  parameter int FLEN      = 32,
  parameter bit FP_EN     = 1'b1,
  parameter bit BYPASS_EN = 1'b1
) (
  input logic            clk,
  input logic            rst,
  decode_issue_if.master bus
);
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_FLW = 7'b0000111, OP_STORE = 7'b0100011,
                         OP_FSW = 7'b0100111, OP_BRANCH = 7'b1100011, OP_FP = 7'b1010011,
                         OP_IMM = 7'b0010011, OP_JALR = 7'b1100111, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_REG = 7'b0110011,
                         OP_AMO = 7'b0101111;

  logic [6:0] opcode, funct7;
  logic [4:0] rs1, rs2, rd;
  assign opcode = bus.InstrD[6:0];
  assign rd     = bus.InstrD[11:7];
  assign rs1    = bus.InstrD[19:15];
  assign rs2    = bus.InstrD[24:20];
  assign funct7 = bus.InstrD[31:25];

  logic c_ld, c_flw, c_st, c_fsw, c_br, c_fp, fp_unary;
  logic rs1_fp, rs2_fp, rs1_used, rs2_used;
  assign c_ld  = (opcode == OP_LOAD);
  assign c_flw = (opcode == OP_FLW);
  assign c_st  = (opcode == OP_STORE);
  assign c_fsw = (opcode == OP_FSW);
  assign c_br  = (opcode == OP_BRANCH);
  assign c_fp  = (opcode == OP_FP);

  // FP ops whose rs2 field is a selector rather than a register (sqrt, converts, moves, class)
  assign fp_unary = funct7 inside {7'b0101100, 7'b0100000, 7'b1100000, 7'b1101000,
                                   7'b1110000, 7'b1111000};
  assign rs1_used = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign rs2_used = (opcode inside {OP_REG, OP_STORE, OP_FSW, OP_BRANCH, OP_AMO}) ||
                    (c_fp && !fp_unary);
  assign rs1_fp   = c_fp && !(funct7 == 7'b1101000 || funct7 == 7'b1111000);
  assign rs2_fp   = c_fp || c_fsw;

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  always_comb begin
    imm32 = '0;
    case (opcode)
      OP_LOAD, OP_FLW, OP_IMM, OP_JALR: imm32 = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
      OP_STORE, OP_FSW: imm32 = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
      OP_BRANCH: imm32 = {{19{bus.InstrD[31]}}, bus.InstrD[31], bus.InstrD[7],
                          bus.InstrD[30:25], bus.InstrD[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm32 = {bus.InstrD[31:12], 12'b0};
      OP_JAL: imm32 = {{11{bus.InstrD[31]}}, bus.InstrD[31], bus.InstrD[19:12],
                       bus.InstrD[20], bus.InstrD[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end
  assign imm = XLEN'($signed(imm32));

  logic            out_valid_q, adv, hazard, in_ready, issue;
  logic [31:0]     iset, iclr, ibusy_q, ibusy_eff, fset, fclr, fbusy_eff;
  logic [XLEN-1:0] int_rd1, int_rd2;
  logic [FLEN-1:0] fp_rd1, fp_rd2;

  logic [XLEN-1:0] irf_q [32];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) irf_q[i] <= '0;
    end else if (bus.RegWriteW && bus.RD_W != 5'd0) begin
      irf_q[bus.RD_W] <= bus.ResultW;
    end
  end

  always_comb begin
    int_rd1 = irf_q[rs1];
    int_rd2 = irf_q[rs2];
    if (BYPASS_EN && bus.RegWriteW && bus.RD_W == rs1) int_rd1 = bus.ResultW;
    if (BYPASS_EN && bus.RegWriteW && bus.RD_W == rs2) int_rd2 = bus.ResultW;
    if (rs1 == 5'd0) int_rd1 = '0;
    if (rs2 == 5'd0) int_rd2 = '0;
  end

  // Clear-before-set so a completing load can release a dependent in the same cycle
  assign iclr      = (bus.ld_done_w && !bus.ld_fp_w) ? (32'd1 << bus.ld_rd_w) : 32'd0;
  assign iset      = (issue && c_ld && rd != 5'd0) ? (32'd1 << rd) : 32'd0;
  assign ibusy_eff = ibusy_q & ~iclr & ~32'd1;
  assign fclr      = (bus.ld_done_w && bus.ld_fp_w) ? (32'd1 << bus.ld_rd_w) : 32'd0;
  assign fset      = (issue && c_flw) ? (32'd1 << rd) : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ibusy_q <= '0;
    else     ibusy_q <= (ibusy_q & ~iclr) | iset;
  end

  if (FP_EN) begin : g_fp
    logic [FLEN-1:0] frf_q [32];
    logic [31:0]     fbusy_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) frf_q[i] <= '0;
        fbusy_q <= '0;
      end else begin
        if (bus.FPRegWriteW) frf_q[bus.FP_RD_W] <= bus.FP_ResultW;
        fbusy_q <= (fbusy_q & ~fclr) | fset;
      end
    end
    always_comb begin
      fp_rd1 = frf_q[rs1];
      fp_rd2 = frf_q[rs2];
      if (BYPASS_EN && bus.FPRegWriteW && bus.FP_RD_W == rs1) fp_rd1 = bus.FP_ResultW;
      if (BYPASS_EN && bus.FPRegWriteW && bus.FP_RD_W == rs2) fp_rd2 = bus.FP_ResultW;
    end
    assign fbusy_eff = fbusy_q & ~fclr;
  end else begin : g_nofp
    assign fp_rd1    = '0;
    assign fp_rd2    = '0;
    assign fbusy_eff = '0;
  end

  assign hazard = bus.in_valid &&
                  ((rs1_used && (rs1_fp ? fbusy_eff[rs1] : ibusy_eff[rs1])) ||
                   (rs2_used && (rs2_fp ? fbusy_eff[rs2] : ibusy_eff[rs2])));
  assign adv      = !out_valid_q || bus.out_ready;
  assign in_ready = adv && !hazard && !bus.flush_d;
  assign issue    = bus.in_valid && in_ready;

  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q, rd1_q, rd2_q, imm_q;
  logic [FLEN-1:0] frd1_q, frd2_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic            fp_q, ld_q, st_q, br_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      {instr_q, pc_q, rd1_q, rd2_q, imm_q, frd1_q, frd2_q} <= '0;
      {rs1_q, rs2_q, rd_q, fp_q, ld_q, st_q, br_q} <= '0;
    end else if (issue) begin
      out_valid_q <= 1'b1;
      instr_q     <= bus.InstrD;
      pc_q        <= bus.PCD;
      rd1_q       <= int_rd1;
      rd2_q       <= int_rd2;
      frd1_q      <= fp_rd1;
      frd2_q      <= fp_rd2;
      imm_q       <= imm;
      rs1_q       <= rs1;
      rs2_q       <= rs2;
      rd_q        <= rd;
      fp_q        <= FP_EN && (c_fp || c_flw || c_fsw);
      ld_q        <= c_ld || c_flw;
      st_q        <= c_st || c_fsw;
      br_q        <= c_br;
    end else if (adv || bus.flush_d) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.InstrE     = instr_q;
  assign bus.PCE        = pc_q;
  assign bus.RD1E       = rd1_q;
  assign bus.RD2E       = rd2_q;
  assign bus.FPRD1E     = frd1_q;
  assign bus.FPRD2E     = frd2_q;
  assign bus.ImmE       = imm_q;
  assign bus.RS1E       = rs1_q;
  assign bus.RS2E       = rs2_q;
  assign bus.RDE        = rd_q;
  assign bus.is_fpE     = fp_q;
  assign bus.is_loadE   = ld_q;
  assign bus.is_storeE  = st_q;
  assign bus.is_branchE = br_q;
endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: bypass on/off, int and FP load-use stalls,
// output back-pressure, flush and asynchronous reset.
module tb_decode_issue_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  decode_issue_if #(.XLEN(32), .FLEN(32)) ifa ();
  decode_issue_if #(.XLEN(32), .FLEN(32)) ifb ();

  decode_issue_stage #(.XLEN(32), .FLEN(32), .FP_EN(1'b1), .BYPASS_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.master));
  decode_issue_stage #(.XLEN(32), .FLEN(32), .FP_EN(1'b1), .BYPASS_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.master));

  localparam logic [31:0] ADD_6_5_0  = 32'h00028333;
  localparam logic [31:0] LW_7       = 32'h0000A383;
  localparam logic [31:0] ADD_8_7_1  = 32'h00138433;
  localparam logic [31:0] FLW_3      = 32'h0000A187;
  localparam logic [31:0] FADD_4_3_2 = 32'h00218253;
  localparam logic [31:0] ADDI_M1    = 32'hFFF00093;
  localparam logic [31:0] SW_M4      = 32'hFE20AE23;
  localparam logic [31:0] LUI_12345  = 32'h123452B7;
  localparam logic [31:0] BEQ_8      = 32'h00000463;
  localparam logic [31:0] LW_9       = 32'h0000A483;
  localparam logic [31:0] ADD_1_9_0  = 32'h000480B3;
  localparam logic [31:0] LW_10      = 32'h0000A503;
  localparam logic [31:0] ADD_11_10  = 32'h000505B3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit both);
    ifa.in_valid = 0; ifa.InstrD = '0; ifa.PCD = '0; ifa.flush_d = 0;
    ifa.RegWriteW = 0; ifa.RD_W = '0; ifa.ResultW = '0;
    ifa.FPRegWriteW = 0; ifa.FP_RD_W = '0; ifa.FP_ResultW = '0;
    ifa.ld_done_w = 0; ifa.ld_rd_w = '0; ifa.ld_fp_w = 0; ifa.out_ready = 1;
    if (both) begin
      ifb.in_valid = 0; ifb.InstrD = '0; ifb.PCD = '0; ifb.flush_d = 0;
      ifb.RegWriteW = 0; ifb.RD_W = '0; ifb.ResultW = '0;
      ifb.FPRegWriteW = 0; ifb.FP_RD_W = '0; ifb.FP_ResultW = '0;
      ifb.ld_done_w = 0; ifb.ld_rd_w = '0; ifb.ld_fp_w = 0; ifb.out_ready = 1;
    end
  endtask

  initial begin
    idle(1'b1);
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("reset_out_valid", ifa.out_valid, 1'b0);
    chk("reset_instrE", ifa.InstrE, 32'h0);
    chk("reset_in_ready", ifa.in_ready, 1'b1);

    // Same-cycle writeback of x5 while decoding add x6,x5,x0
    ifa.in_valid = 1; ifa.InstrD = ADD_6_5_0; ifa.PCD = 32'h100;
    ifa.RegWriteW = 1; ifa.RD_W = 5'd5; ifa.ResultW = 32'h1234;
    ifb.in_valid = 1; ifb.InstrD = ADD_6_5_0;
    ifb.RegWriteW = 1; ifb.RD_W = 5'd5; ifb.ResultW = 32'h1234;
    #1 chk("bypass_in_ready", ifa.in_ready, 1'b1);
    step();
    chk("bypass_on_rd1", ifa.RD1E, 32'h1234);
    chk("bypass_off_rd1", ifb.RD1E, 32'h0);
    chk("bypass_valid", ifa.out_valid, 1'b1);
    chk("bypass_pcE", ifa.PCE, 32'h100);
    chk("bypass_rs1E", ifa.RS1E, 5'd5);
    chk("bypass_rdE", ifa.RDE, 5'd6);
    idle(1'b1);
    step();
    chk("drain_valid", ifa.out_valid, 1'b0);

    // Integer load-use
    ifa.in_valid = 1; ifa.InstrD = LW_7;
    step();
    chk("lw_loadE", ifa.is_loadE, 1'b1);
    chk("lw_rdE", ifa.RDE, 5'd7);
    ifa.InstrD = ADD_8_7_1;
    #1 chk("lu_stall0", ifa.in_ready, 1'b0);
    step();
    chk("lu_stall1", ifa.in_ready, 1'b0);
    chk("lu_bubble", ifa.out_valid, 1'b0);
    ifa.ld_done_w = 1; ifa.ld_rd_w = 5'd7; ifa.ld_fp_w = 0;
    ifa.RegWriteW = 1; ifa.RD_W = 5'd7; ifa.ResultW = 32'hCAFE;
    #1 chk("lu_release", ifa.in_ready, 1'b1);
    step();
    chk("lu_instrE", ifa.InstrE, ADD_8_7_1);
    chk("lu_rd1E", ifa.RD1E, 32'hCAFE);
    chk("lu_valid", ifa.out_valid, 1'b1);
    idle(1'b0);

    // FP load-use; wrong-file completion must not release
    ifa.in_valid = 1; ifa.InstrD = FLW_3;
    step();
    chk("flw_fpE", ifa.is_fpE, 1'b1);
    ifa.InstrD = FADD_4_3_2;
    #1 chk("fp_stall0", ifa.in_ready, 1'b0);
    ifa.ld_done_w = 1; ifa.ld_rd_w = 5'd3; ifa.ld_fp_w = 0;
    #1 chk("fp_wrong_file", ifa.in_ready, 1'b0);
    step();
    chk("fp_still_stall", ifa.in_ready, 1'b0);
    ifa.ld_fp_w = 1;
    ifa.FPRegWriteW = 1; ifa.FP_RD_W = 5'd3; ifa.FP_ResultW = 32'h3F800000;
    #1 chk("fp_release", ifa.in_ready, 1'b1);
    step();
    chk("fp_instrE", ifa.InstrE, FADD_4_3_2);
    chk("fp_frd1E", ifa.FPRD1E, 32'h3F800000);
    chk("fp_fpE", ifa.is_fpE, 1'b1);
    idle(1'b0);

    // Back-pressure then back-to-back issue
    ifa.in_valid = 1; ifa.InstrD = ADDI_M1;
    step();
    chk("addi_imm", ifa.ImmE, 32'hFFFFFFFF);
    ifa.out_ready = 0; ifa.InstrD = SW_M4;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", ifa.in_ready, 1'b0);
      step();
      chk("bp_hold_instr", ifa.InstrE, ADDI_M1);
      chk("bp_hold_valid", ifa.out_valid, 1'b1);
    end
    ifa.out_ready = 1;
    #1 chk("bp_release", ifa.in_ready, 1'b1);
    step();
    chk("sw_imm", ifa.ImmE, 32'hFFFFFFFC);
    chk("sw_storeE", ifa.is_storeE, 1'b1);
    ifa.InstrD = LUI_12345;
    step();
    chk("lui_instr", ifa.InstrE, LUI_12345);
    chk("lui_imm", ifa.ImmE, 32'h12345000);
    ifa.InstrD = BEQ_8;
    step();
    chk("beq_imm", ifa.ImmE, 32'h8);
    chk("beq_branchE", ifa.is_branchE, 1'b1);
    chk("b2b_valid", ifa.out_valid, 1'b1);

    // Flush kills lw x9 without marking x9 busy
    ifa.InstrD = LW_9; ifa.flush_d = 1;
    #1 chk("flush_in_ready", ifa.in_ready, 1'b0);
    step();
    ifa.flush_d = 0;
    chk("flush_valid", ifa.out_valid, 1'b0);
    ifa.InstrD = ADD_1_9_0;
    #1 chk("flush_no_busy", ifa.in_ready, 1'b1);
    step();
    chk("flush_next_instr", ifa.InstrE, ADD_1_9_0);
    chk("flush_next_valid", ifa.out_valid, 1'b1);

    // Async reset mid-stream with a pending load-use stall
    ifa.InstrD = LW_10;
    step();
    ifa.InstrD = ADD_11_10;
    #1 chk("pre_rst_stall", ifa.in_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", ifa.out_valid, 1'b0);
    chk("rst_async_instr", ifa.InstrE, 32'h0);
    chk("rst_async_rd1", ifa.RD1E, 32'h0);
    chk("rst_sb_clear", ifa.in_ready, 1'b1);
    #1 rst = 1'b0;
    step();
    chk("post_rst_instr", ifa.InstrE, ADD_11_10);
    chk("post_rst_valid", ifa.out_valid, 1'b1);
    idle(1'b1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
